// File: rtl/riscv_mem_arbiter.sv
// Shares one block-wide DRAM port between the I-cache refill and D-cache refill/write-back paths.
// Build option RISCV_ARB_RR_EN: round-robin on simultaneous requests (default: D side has priority).
module riscv_mem_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int S_ADDR     = 10
) (
    input  logic                  i_riscv_arb_clk,
    input  logic                  i_riscv_arb_rst,
    input  logic                  i_riscv_arb_d_wren,
    input  logic                  i_riscv_arb_d_rden,
    input  logic [S_ADDR-1:0]     i_riscv_arb_d_addr,
    input  logic [DATA_WIDTH-1:0] i_riscv_arb_d_wdata,
    output logic [DATA_WIDTH-1:0] o_riscv_arb_d_rdata,
    output logic                  o_riscv_arb_d_ready,
    input  logic                  i_riscv_arb_i_rden,
    input  logic [S_ADDR-1:0]     i_riscv_arb_i_addr,
    output logic [DATA_WIDTH-1:0] o_riscv_arb_i_rdata,
    output logic                  o_riscv_arb_i_ready,
    output logic                  o_riscv_arb_mem_wren,
    output logic                  o_riscv_arb_mem_rden,
    output logic [S_ADDR-1:0]     o_riscv_arb_mem_addr,
    output logic [DATA_WIDTH-1:0] o_riscv_arb_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_riscv_arb_mem_rdata,
    input  logic                  i_riscv_arb_mem_ready
);

    typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    mem_wren_q, mem_wren_d;
    logic                    mem_rden_q, mem_rden_d;
    logic [S_ADDR-1:0]       mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
    logic [DATA_WIDTH-1:0]   i_rdata_q, i_rdata_d;
    logic                    d_ready_q, d_ready_d;
    logic                    i_ready_q, i_ready_d;
    logic                    d_req, i_req, grant_d;
`ifdef RISCV_ARB_RR_EN
    logic                    last_d_q, last_d_d;   // 1: D side won the most recent grant
`endif

    assign d_req = i_riscv_arb_d_wren | i_riscv_arb_d_rden;
    assign i_req = i_riscv_arb_i_rden;

`ifdef RISCV_ARB_RR_EN
    assign grant_d = d_req & (~i_req | ~last_d_q);
`else
    assign grant_d = d_req;
`endif

    always_comb begin
        state_d     = state_q;
        mem_wren_d  = mem_wren_q;
        mem_rden_d  = mem_rden_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        d_rdata_d   = d_rdata_q;
        i_rdata_d   = i_rdata_q;
        d_ready_d   = 1'b0;
        i_ready_d   = 1'b0;
`ifdef RISCV_ARB_RR_EN
        last_d_d    = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    // A write wins over a simultaneous read on the D side.
                    mem_wren_d  = i_riscv_arb_d_wren;
                    mem_rden_d  = i_riscv_arb_d_rden & ~i_riscv_arb_d_wren;
                    mem_addr_d  = i_riscv_arb_d_addr;
                    mem_wdata_d = i_riscv_arb_d_wdata;
                    state_d     = D_BUSY;
`ifdef RISCV_ARB_RR_EN
                    last_d_d    = 1'b1;
`endif
                end else if (i_req) begin
                    mem_rden_d  = 1'b1;
                    mem_addr_d  = i_riscv_arb_i_addr;
                    state_d     = I_BUSY;
`ifdef RISCV_ARB_RR_EN
                    last_d_d    = 1'b0;
`endif
                end
            end
            D_BUSY, I_BUSY: begin
                if (i_riscv_arb_mem_ready) begin
                    mem_wren_d = 1'b0;
                    mem_rden_d = 1'b0;
                    if (state_q == D_BUSY) begin
                        d_ready_d = 1'b1;
                        if (mem_rden_q) d_rdata_d = i_riscv_arb_mem_rdata;
                    end else begin
                        i_ready_d = 1'b1;
                        i_rdata_d = i_riscv_arb_mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_riscv_arb_clk or negedge i_riscv_arb_rst) begin
        if (!i_riscv_arb_rst) begin
            state_q     <= IDLE;
            mem_wren_q  <= 1'b0;
            mem_rden_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            d_rdata_q   <= '0;
            i_rdata_q   <= '0;
            d_ready_q   <= 1'b0;
            i_ready_q   <= 1'b0;
`ifdef RISCV_ARB_RR_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_wren_q  <= mem_wren_d;
            mem_rden_q  <= mem_rden_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            d_rdata_q   <= d_rdata_d;
            i_rdata_q   <= i_rdata_d;
            d_ready_q   <= d_ready_d;
            i_ready_q   <= i_ready_d;
`ifdef RISCV_ARB_RR_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    assign o_riscv_arb_mem_wren  = mem_wren_q;
    assign o_riscv_arb_mem_rden  = mem_rden_q;
    assign o_riscv_arb_mem_addr  = mem_addr_q;
    assign o_riscv_arb_mem_wdata = mem_wdata_q;
    assign o_riscv_arb_d_rdata   = d_rdata_q;
    assign o_riscv_arb_i_rdata   = i_rdata_q;
    assign o_riscv_arb_d_ready   = d_ready_q;
    assign o_riscv_arb_i_ready   = i_ready_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed plus randomized checks of riscv_mem_arbiter against a DRAM model and a reference memory.
module tb_riscv_mem_arbiter;
    localparam int DW = 128;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          d_wren, d_rden, i_rden;
    logic [AW-1:0] d_addr, i_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata, i_rdata;
    logic          d_ready, i_ready;
    logic          mem_wren, mem_rden;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.DATA_WIDTH(DW), .S_ADDR(AW)) dut (
        .i_riscv_arb_clk      (clk),
        .i_riscv_arb_rst      (rst_n),
        .i_riscv_arb_d_wren   (d_wren),
        .i_riscv_arb_d_rden   (d_rden),
        .i_riscv_arb_d_addr   (d_addr),
        .i_riscv_arb_d_wdata  (d_wdata),
        .o_riscv_arb_d_rdata  (d_rdata),
        .o_riscv_arb_d_ready  (d_ready),
        .i_riscv_arb_i_rden   (i_rden),
        .i_riscv_arb_i_addr   (i_addr),
        .o_riscv_arb_i_rdata  (i_rdata),
        .o_riscv_arb_i_ready  (i_ready),
        .o_riscv_arb_mem_wren (mem_wren),
        .o_riscv_arb_mem_rden (mem_rden),
        .o_riscv_arb_mem_addr (mem_addr),
        .o_riscv_arb_mem_wdata(mem_wdata),
        .i_riscv_arb_mem_rdata(mem_rdata),
        .i_riscv_arb_mem_ready(mem_ready)
    );

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] dram    [1024];
    logic [DW-1:0] ref_mem [1024];
    logic [DW-1:0] exp_d, exp_i;
    int            lat = 0;
    int            cnt = 0;
    bit            both_seen = 0;
    logic [AW-1:0] served_addr[$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // DRAM model: raises mem_ready for one cycle after `lat` idle enable cycles.
    always @(negedge clk) begin
        if (mem_wren && mem_rden) both_seen = 1;
        if (!rst_n) begin
            mem_ready = 1'b0;
            cnt = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            cnt = 0;
        end else if (mem_wren || mem_rden) begin
            if (cnt >= lat) begin
                mem_ready = 1'b1;
                served_addr.push_back(mem_addr);
                if (mem_wren) dram[mem_addr] = mem_wdata;
                else          mem_rdata = dram[mem_addr];
            end else begin
                cnt++;
            end
        end else begin
            cnt = 0;
        end
    end

    task automatic wait_ready(input bit is_d, output int n);
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (is_d ? d_ready : i_ready) return;
        end
        n = -1;
    endtask

    task automatic run_txn(input bit is_d, input bit wr, input bit rd, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input int l, input string tag);
        int waited;
        bit got, stable_ok, other_ok, en_first;
        lat = l;
        @(negedge clk);
        if (is_d) begin
            d_wren = wr; d_rden = rd; d_addr = a; d_wdata = wd;
        end else begin
            i_rden = 1'b1; i_addr = a;
        end
        waited = 0; got = 0; stable_ok = 1; other_ok = 1; en_first = 0;
        while (!got && waited < 300) begin
            @(negedge clk);
            waited++;
            got = is_d ? d_ready : i_ready;
            if (is_d ? i_ready : d_ready) other_ok = 0;
            if (waited == 1) en_first = mem_wren | mem_rden;
            if (mem_wren || mem_rden) begin
                if (mem_addr !== a || mem_wren !== (is_d & wr) || mem_rden !== (rd & ~(is_d & wr))
                    || (is_d && wr && mem_wdata !== wd)) stable_ok = 0;
            end
        end
        d_wren = 1'b0; d_rden = 1'b0; i_rden = 1'b0;
        check({tag, "_ready_seen"}, DW'(got), DW'(1));
        check({tag, "_grant_next_cycle"}, DW'(en_first), DW'(1));
        // Grant at the first edge, mem_ready sampled l+1 edges later, ready visible after that edge.
        check({tag, "_latency"}, DW'(waited), DW'(2 + l));
        check({tag, "_mem_port"}, DW'(stable_ok), DW'(1));
        check({tag, "_other_ready_quiet"}, DW'(other_ok), DW'(1));
        if (is_d && wr) ref_mem[a] = wd;
        else if (is_d) exp_d = ref_mem[a];
        else           exp_i = ref_mem[a];
        check({tag, "_d_rdata"}, d_rdata, exp_d);
        check({tag, "_i_rdata"}, i_rdata, exp_i);
        @(negedge clk);
        check({tag, "_ready_pulse_1cyc"}, DW'({d_ready, i_ready}), DW'(0));
        $display("[TB] txn %s side=%s wr=%0b rd=%0b addr=%03h lat=%0d cycles=%0d",
                 tag, is_d ? "D" : "I", wr, rd, a, l, waited);
    endtask

    initial begin
        int n, gap;
        bit r_d, r_wr;
        logic [DW-1:0] r_data;

        rst_n = 1'b0;
        d_wren = 0; d_rden = 0; i_rden = 0;
        d_addr = '0; i_addr = '0; d_wdata = '0;
        for (int k = 0; k < 1024; k++) begin
            dram[k] = {$urandom, $urandom, $urandom, $urandom};
            ref_mem[k] = dram[k];
        end
        dram[10'h3A5]    = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
        ref_mem[10'h3A5] = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
        exp_d = '0; exp_i = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_wren", DW'(mem_wren), DW'(0));
        check("rst_mem_rden", DW'(mem_rden), DW'(0));
        check("rst_ready", DW'({d_ready, i_ready}), DW'(0));
        check("rst_d_rdata", d_rdata, '0);
        check("rst_i_rdata", i_rdata, '0);
        check("rst_mem_addr_data", {mem_wdata[DW-1-AW:0], mem_addr}, '0);
        rst_n = 1'b1;

        run_txn(0, 0, 1, 10'h3A5, '0, 4, "i_read_3a5");
        run_txn(1, 1, 0, 10'h010, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_5678, 1, "d_wb_010");
        run_txn(1, 0, 1, 10'h010, '0, 0, "d_read_010");
        run_txn(1, 1, 1, 10'h055, 128'hA5A5_5A5A_0000_FFFF_1357_2468_CAFE_F00D, 2, "d_wr_rd_055");
        check("d_wr_rd_no_read", DW'(both_seen), DW'(0));
        run_txn(1, 0, 1, 10'h055, '0, 3, "d_read_055");

        // Simultaneous D and I reads: D first, I granted two edges after D's ready.
        served_addr.delete();
        lat = 1;
        @(negedge clk);
        d_rden = 1; d_addr = 10'h020; i_rden = 1; i_addr = 10'h040;
        wait_ready(1, n);
        d_rden = 0;
        check("sim_d_ready", DW'(n > 0), DW'(1));
        exp_d = ref_mem[10'h020];
        check("sim_d_rdata", d_rdata, exp_d);
        gap = 0;
        while (gap < 20) begin
            @(negedge clk);
            gap++;
            if (mem_rden) break;
        end
        check("sim_gap", DW'(gap), DW'(2));
        check("sim_i_addr", DW'(mem_addr), DW'(10'h040));
        wait_ready(0, n);
        i_rden = 0;
        check("sim_i_ready", DW'(n > 0), DW'(1));
        exp_i = ref_mem[10'h040];
        check("sim_i_rdata", i_rdata, exp_i);
        check("sim_order_n", DW'(served_addr.size()), DW'(2));
        if (served_addr.size() == 2) begin
            check("sim_order_0", DW'(served_addr[0]), DW'(10'h020));
            check("sim_order_1", DW'(served_addr[1]), DW'(10'h040));
        end
        $display("[TB] txn simultaneous D=020 I=040");
        @(negedge clk);

        // Both sides held for four grants; the previous grant went to I.
        served_addr.delete();
        lat = 0;
        @(negedge clk);
        d_rden = 1; d_addr = 10'h0A0; i_rden = 1; i_addr = 10'h0B0;
        n = 0;
        while (served_addr.size() < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        d_rden = 0; i_rden = 0;
        repeat (6) @(negedge clk);
        check("held_count", DW'(served_addr.size()), DW'(4));
        for (int k = 0; k < 4 && k < served_addr.size(); k++) begin
`ifdef RISCV_ARB_RR_EN
            check($sformatf("held_order_%0d", k), DW'(served_addr[k]), DW'((k % 2 == 0) ? 10'h0A0 : 10'h0B0));
`else
            check($sformatf("held_order_%0d", k), DW'(served_addr[k]), DW'(10'h0A0));
`endif
        end
        exp_d = ref_mem[10'h0A0];
`ifdef RISCV_ARB_RR_EN
        exp_i = ref_mem[10'h0B0];
`endif
        check("held_d_rdata", d_rdata, exp_d);
        check("held_i_rdata", i_rdata, exp_i);
        $display("[TB] txn held D=0A0 I=0B0 grants=%0d", served_addr.size());

        // Reset in the middle of a D read, then the pending request is re-granted.
        lat = 30;
        @(negedge clk);
        d_rden = 1; d_addr = 10'h123;
        repeat (3) @(negedge clk);
        check("mid_busy_rden", DW'(mem_rden), DW'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rden", DW'({mem_rden, mem_wren}), DW'(0));
        check("async_rst_addr", DW'(mem_addr), DW'(0));
        check("async_rst_rdata", d_rdata | i_rdata, '0);
        exp_d = '0; exp_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        lat = 1;
        @(negedge clk);
        check("regrant_rden", DW'(mem_rden), DW'(1));
        check("regrant_addr", DW'(mem_addr), DW'(10'h123));
        wait_ready(1, n);
        d_rden = 0;
        check("regrant_ready", DW'(n > 0), DW'(1));
        exp_d = ref_mem[10'h123];
        check("regrant_d_rdata", d_rdata, exp_d);
        check("regrant_i_rdata", i_rdata, exp_i);
        $display("[TB] txn reset_mid_d_read addr=123");
        @(negedge clk);

        for (int t = 0; t < 24; t++) begin
            r_d = 1'($urandom_range(0, 1));
            r_wr = r_d & 1'($urandom_range(0, 1));
            r_data = {$urandom, $urandom, $urandom, $urandom};
            run_txn(r_d, r_wr, ~r_wr, 10'($urandom_range(0, 15)), r_data,
                    int'($urandom_range(0, 4)), $sformatf("rnd%0d", t));
        end
        check("never_both_enables", DW'(both_seen), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
